// File: rtl/ym_dbg_pkg.sv
// ym_dbg_pkg: shared types and helpers for the debug-chain capture engine.
// Contents: shifter state enum, bit-counter width helper.
// No ports; imported by ym_dbg_capture and its sub-modules.
package ym_dbg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } dbg_state_e;

  // Width of the per-frame bit counter; it only has to reach width-1.
  function automatic int ym_dbg_cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/ym_dbg_capture_if.sv
// ym_dbg_capture_if: chain-side inputs plus host-side word handshake of the capture engine.
// Signals: c1/c2/load/sdata (chain), dout/dout_valid/dout_ready (host), busy, ovf, ovf_cnt.
// master = chain driver + host, slave = capture engine.
interface ym_dbg_capture_if #(
  parameter int FRAME_WIDTH = 16
) ();
  logic                   c1;
  logic                   c2;
  logic                   load;
  logic                   sdata;
  logic [FRAME_WIDTH-1:0] dout;
  logic                   dout_valid;
  logic                   dout_ready;
  logic                   busy;
  logic                   ovf;
  logic [7:0]             ovf_cnt;

  modport master (
    output c1, c2, load, sdata, dout_ready,
    input  dout, dout_valid, busy, ovf, ovf_cnt
  );

  modport slave (
    input  c1, c2, load, sdata, dout_ready,
    output dout, dout_valid, busy, ovf, ovf_cnt
  );
endinterface

// File: rtl/ym_dbg_obuf.sv
// ym_dbg_obuf: single-entry output buffer between the shifter and the host.
// Ports: MCLK, reset (sync, active-high), wr_vld/wr_dat (completed frame), rd_rdy (host ready),
//        dout/full (registered word + valid), drop (combinational: frame lost because buffer busy).
module ym_dbg_obuf #(
  parameter int WIDTH = 16
) (
  input  logic             MCLK,
  input  logic             reset,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             drop
);
  logic take;
  logic accept;

  // A word leaving on this edge frees the slot for a word arriving on the same edge.
  assign take   = full & rd_rdy;
  assign accept = wr_vld & (~full | take);
  assign drop   = wr_vld & ~accept;

  always_ff @(posedge MCLK) begin
    if (reset) begin
      dout <= '0;
      full <= 1'b0;
    end else if (accept) begin
      dout <= wr_dat;
      full <= 1'b1;
    end else if (take) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/ym_dbg_capture.sv
// ym_dbg_capture: reassembles LSB-first debug-chain frames (sampled on c1) into parallel words.
// Ports: MCLK, reset (sync, active-high), bus (slave modport of ym_dbg_capture_if).
// Macro YM_DBG_CAPTURE_OVF_EN builds the sticky ovf flag and saturating ovf_cnt; otherwise both read 0.
module ym_dbg_capture
  import ym_dbg_pkg::*;
#(
  parameter int FRAME_WIDTH = 16
) (
  input logic             MCLK,
  input logic             reset,
  ym_dbg_capture_if.slave bus
);
  localparam int            CW       = ym_dbg_cnt_w(FRAME_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_WIDTH - 1);

  dbg_state_e             state;
  logic [CW-1:0]          bitcnt;
  logic [FRAME_WIDTH-1:0] sr;
  logic [FRAME_WIDTH-1:0] word;
  logic                   sample;
  logic                   frame_done;
  logic                   frame_drop;

  // load takes priority over sampling, so a load strobe never contributes a bit.
  assign sample     = bus.c1 & ~bus.load & (state == SHIFT);
  assign frame_done = sample & (bitcnt == LAST_BIT);
  assign word       = {bus.sdata, sr[FRAME_WIDTH-1:1]};

  always_ff @(posedge MCLK) begin
    if (reset) begin
      state  <= IDLE;
      bitcnt <= '0;
      sr     <= '0;
    end else if (bus.c1 & bus.load) begin
      // Frame start; also silently aborts any partial frame.
      state  <= SHIFT;
      bitcnt <= '0;
      sr     <= '0;
    end else if (sample) begin
      sr <= word;
      if (bitcnt == LAST_BIT) begin
        state  <= IDLE;
        bitcnt <= '0;
      end else begin
        bitcnt <= bitcnt + 1'b1;
      end
    end
  end

  assign bus.busy = (state == SHIFT);

  ym_dbg_obuf #(
    .WIDTH(FRAME_WIDTH)
  ) u_obuf (
    .MCLK   (MCLK),
    .reset  (reset),
    .wr_vld (frame_done),
    .wr_dat (word),
    .rd_rdy (bus.dout_ready),
    .dout   (bus.dout),
    .full   (bus.dout_valid),
    .drop   (frame_drop)
  );

`ifdef YM_DBG_CAPTURE_OVF_EN
  logic       ovf_q;
  logic [7:0] ovf_cnt_q;

  always_ff @(posedge MCLK) begin
    if (reset) begin
      ovf_q     <= 1'b0;
      ovf_cnt_q <= '0;
    end else if (frame_drop) begin
      ovf_q <= 1'b1;
      if (ovf_cnt_q != 8'hFF) begin
        ovf_cnt_q <= ovf_cnt_q + 8'd1;
      end
    end
  end

  assign bus.ovf     = ovf_q;
  assign bus.ovf_cnt = ovf_cnt_q;

  // c2 is only meaningful to the overlap check; sr[0] is the bit shifted out.
  logic unused_ok;
  assign unused_ok = ^{bus.c2, sr[0]};
`else
  assign bus.ovf     = 1'b0;
  assign bus.ovf_cnt = '0;

  logic unused_ok;
  assign unused_ok = ^{bus.c2, sr[0], frame_drop};
`endif

endmodule

// File: tb/tb_ym_dbg_capture.sv
module tb_ym_dbg_capture;
  import ym_dbg_pkg::*;

  localparam int W = 8;

  logic MCLK = 1'b0;
  logic rst  = 1'b1;

  ym_dbg_capture_if #(.FRAME_WIDTH(W)) bus ();

  ym_dbg_capture #(.FRAME_WIDTH(W)) dut (
    .MCLK  (MCLK),
    .reset (rst),
    .bus   (bus)
  );

  always #5 MCLK = ~MCLK;

  int n_chk  = 0;
  int n_fail = 0;
  bit running = 1'b0;

  // Reference model: a one-slot host queue fed by whole frames rebuilt from a bit list.
  bit             m_occ;
  bit             m_in_frame;
  bit             m_bits[$];
  int             m_drops;
  logic [W-1:0]   exp_q[$];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endfunction

  function automatic int sat_drops();
    return (m_drops > 255) ? 255 : m_drops;
  endfunction

  // Applies one clock edge to the model using the inputs the DUT sees on that edge.
  task automatic model_edge();
    bit           hs;
    bit           done;
    logic [W-1:0] w;
    if (rst) begin
      m_occ      = 1'b0;
      m_in_frame = 1'b0;
      m_bits.delete();
      m_drops    = 0;
      exp_q.delete();
      return;
    end
    hs   = m_occ && bus.dout_ready;
    done = 1'b0;
    w    = '0;
    if (bus.c1 && bus.load) begin
      m_in_frame = 1'b1;
      m_bits.delete();
    end else if (bus.c1 && m_in_frame) begin
      m_bits.push_back(bus.sdata);
      if (m_bits.size() == W) begin
        for (int k = 0; k < W; k++) w[k] = m_bits[k];
        done       = 1'b1;
        m_in_frame = 1'b0;
      end
    end
    if (done) begin
      if (!m_occ || hs) begin
        exp_q.push_back(w);
        m_occ = 1'b1;
      end else begin
        m_drops++;
      end
    end else if (hs) begin
      m_occ = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit c1, input bit c2, input bit ld, input bit sd);
    bus.c1    = c1;
    bus.c2    = c2;
    bus.load  = ld;
    bus.sdata = sd;
    tick();
  endtask

  // One two-phase chain step: c1 (sample) cycle then c2 cycle.
  task automatic strobe(input bit ld, input bit sd);
    drive(1'b1, 1'b0, ld, sd);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [W-1:0] w);
    strobe(1'b1, 1'b0);
    for (int k = 0; k < W; k++) strobe(1'b0, w[k]);
  endtask

  task automatic drain();
    bus.dout_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    bus.dout_ready = 1'b0;
  endtask

  // Scoreboard monitor: compares every handshaken word and the status outputs to the model.
  always @(negedge MCLK) begin
    if (running && !rst) begin
      check("dout_valid", 64'(bus.dout_valid), 64'(m_occ));
      check("busy", 64'(bus.busy), 64'(m_in_frame));
`ifdef YM_DBG_CAPTURE_OVF_EN
      check("ovf", 64'(bus.ovf), 64'(m_drops > 0));
      check("ovf_cnt", 64'(bus.ovf_cnt), 64'(sat_drops()));
`else
      check("ovf", 64'(bus.ovf), 64'd0);
      check("ovf_cnt", 64'(bus.ovf_cnt), 64'd0);
`endif
      if (bus.dout_valid && bus.dout_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h, expected no word (t=%0t)", bus.dout, $time);
        end else begin
          check("dout_word", 64'(bus.dout), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  // c1/c2 phase overlap is illegal stimulus.
  always @(posedge MCLK) begin
    if (running && !rst) begin
      n_chk++;
      assert (!(bus.c1 && bus.c2))
      else begin
        n_fail++;
        $display("FAIL phase_overlap: c1=%0b c2=%0b, expected not both high", bus.c1, bus.c2);
      end
    end
  end

  initial begin
    logic [W-1:0] w77;
    bit           c1r;
    bit           c2r;
    bit           ldr;

    bus.c1 = 1'b0; bus.c2 = 1'b0; bus.load = 1'b0; bus.sdata = 1'b0;
    bus.dout_ready = 1'b0;
    rst = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    running = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_dout", 64'(bus.dout), 64'd0);
    check("rst_valid", 64'(bus.dout_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_ovf", 64'(bus.ovf), 64'd0);
    check("rst_ovf_cnt", 64'(bus.ovf_cnt), 64'd0);

    // Basic capture: bits 1,0,1,0,0,1,0,1 -> A5.
    strobe(1'b1, 1'b0);
    check("basic_busy", 64'(bus.busy), 64'd1);
    strobe(1'b0, 1'b1); strobe(1'b0, 1'b0); strobe(1'b0, 1'b1); strobe(1'b0, 1'b0);
    strobe(1'b0, 1'b0); strobe(1'b0, 1'b1); strobe(1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    check("basic_dout", 64'(bus.dout), 64'hA5);
    check("basic_valid", 64'(bus.dout_valid), 64'd1);
    check("basic_busy_low", 64'(bus.busy), 64'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drain();

    // Back-to-back at minimum spacing with ready held high.
    bus.dout_ready = 1'b1;
    send_frame(8'h3C);
    send_frame(8'hC3);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("b2b_ovf", 64'(bus.ovf), 64'd0);
    bus.dout_ready = 1'b0;

    // Overflow: host stalled, second and third frames dropped.
    send_frame(8'h11);
    send_frame(8'h22);
    send_frame(8'h33);
    check("ovf_dout_kept", 64'(bus.dout), 64'h11);
    check("ovf_valid", 64'(bus.dout_valid), 64'd1);
`ifdef YM_DBG_CAPTURE_OVF_EN
    check("ovf_flag", 64'(bus.ovf), 64'd1);
    check("ovf_count", 64'(bus.ovf_cnt), 64'd2);
`else
    check("ovf_flag_off", 64'(bus.ovf), 64'd0);
    check("ovf_count_off", 64'(bus.ovf_cnt), 64'd0);
`endif
    drain();

    // Simultaneous: 77 completes on the edge that hands off 55.
    send_frame(8'h55);
    w77 = 8'h77;
    strobe(1'b1, 1'b0);
    for (int k = 0; k < W - 1; k++) strobe(1'b0, w77[k]);
    bus.dout_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0, w77[W-1]);
    bus.dout_ready = 1'b0;
    check("simul_valid", 64'(bus.dout_valid), 64'd1);
    check("simul_dout", 64'(bus.dout), 64'h77);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drain();

    // Abort: partial frame after 5 strobes is discarded by a new load.
    strobe(1'b1, 1'b0);
    for (int k = 0; k < 5; k++) strobe(1'b0, 1'b1);
    send_frame(8'h0F);
    check("abort_dout", 64'(bus.dout), 64'h0F);
    check("abort_qlen", 64'(exp_q.size()), 64'd1);
    drain();

    // Reset mid-frame with a word pending.
    send_frame(8'h5A);
    strobe(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) strobe(1'b0, 1'b1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    check("midrst_dout", 64'(bus.dout), 64'd0);
    check("midrst_valid", 64'(bus.dout_valid), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_ovf", 64'(bus.ovf), 64'd0);
    check("midrst_ovf_cnt", 64'(bus.ovf_cnt), 64'd0);
    for (int k = 0; k < 12; k++) strobe(1'b0, 1'b1);
    check("stray_valid", 64'(bus.dout_valid), 64'd0);
    check("stray_busy", 64'(bus.busy), 64'd0);

    // Random phase: random chain activity, stalls, aborts and rare resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) bus.dout_ready = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 799) == 0);
      c1r = ($urandom_range(0, 99) < 55);
      ldr = c1r && ($urandom_range(0, 19) == 0);
      c2r = !c1r && ($urandom_range(0, 1) == 1);
      drive(c1r, c2r, ldr, 1'($urandom_range(0, 1)));
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    drain();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ym_dbg_capture.md
# ym_dbg_capture

Serial-to-parallel capture engine for the on-chip debug readout chains. It sits at the receiving end of a chain of parallel-load debug shift cells, which shift LSB first on the two-phase `c1`/`c2` enables. It reassembles each `FRAME_WIDTH`-bit frame into a parallel word and hands it to the host-side debug logic over a valid/ready handshake. A single-entry output buffer decouples the host from the chain, so the next frame can be shifted in while the previous word waits.

## Interface
- `FRAME_WIDTH`, default 16: bits per frame; legal range 2..64.
- `MCLK` input, 1 bit: master clock; all state updates on its posedge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `c1` input, 1 bit: phase-1 enable, the same strobe that clocks the debug chain; sampling occurs only on cycles with `c1`=1.
- `c2` input, 1 bit: phase-2 enable; used only for the `c1`/`c2` overlap check.
- `load` input, 1 bit: the chain's parallel-load strobe; marks frame start when sampled with `c1`=1.
- `sdata` input, 1 bit: serial output of the last cell in the chain.
- `dout` output, `FRAME_WIDTH` bits: captured word, LSB = first bit shifted out.
- `dout_valid` output, 1 bit: `dout` holds an unconsumed word.
- `dout_ready` input, 1 bit: host accepts `dout` when `dout_valid & dout_ready`.
- `busy` output, 1 bit: a frame is being shifted in.
- `ovf` output, 1 bit: sticky overflow flag; present only with the macro.
- `ovf_cnt` output, 8 bits: saturating count of dropped frames; present only with the macro.

## Operation
- Shifter FSM states: `IDLE` and `SHIFT`. The output buffer has a separate `full` flag that drives `dout_valid`.
- **Frame start.** In any state, an edge with `c1 & load` moves the FSM to `SHIFT`, sets `bitcnt`=0 and clears the shift register. No bit is sampled on that edge.
- **Shifting.** In `SHIFT`, each edge with `c1 & ~load`:
  - shifts `sdata` into the MSB (`sr <= {sdata, sr[W-1:1]}`);
  - increments `bitcnt`.
- **Bit ordering.** Bit k of the frame is sampled on the (k+1)-th `c1` strobe after the load strobe.
- **Completion.** On the sample where `bitcnt == FRAME_WIDTH-1`:
  - the assembled word `{sdata, sr[W-1:1]}` is the completed frame;
  - the FSM returns to `IDLE`.
- **Writing the buffer.** The completed word is written to `dout` and `full` is set if either:
  - `full` is 0, or
  - `dout_valid & dout_ready` on the same edge. In that case `dout_valid` stays high and `dout` takes the new word.
- **Overflow.** If neither condition holds, the frame is dropped, `dout` is unchanged and the overflow event fires.
- **Consume.** `dout_valid & dout_ready` with no simultaneous completion clears `full`. `dout` holds its last value.
- **Abort.** `load` during `SHIFT` aborts the partial frame silently; this is not an overflow.
- **Idle sampling.** `c1` edges in `IDLE` without `load` are ignored.
- **Phase overlap.** `c1 & c2` in the same cycle is illegal; the bench flags it via assertion. RTL behaviour is unspecified.
- **Reset** (any cycle, including mid-frame) forces:
  - state `IDLE`, `bitcnt`=0, shift register 0;
  - `dout`=0, `dout_valid`=0, `busy`=0, `ovf`=0, `ovf_cnt`=0.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- `busy` rises the cycle after the load edge and falls the cycle after the completion edge.
- Latency: `dout_valid`/`dout` update in the cycle after the final-bit `c1` edge.
- The handshake completes on the edge where `dout_valid & dout_ready`; `dout_valid` drops the next cycle unless refilled.
- `dout_ready` may be held high permanently; no word is lost when each frame is consumed before the next completes.
- The shortest frame-to-frame spacing is `FRAME_WIDTH+1` `c1` strobes.

## Configuration
- `YM_DBG_CAPTURE_OVF_EN` defined:
  - a dropped frame sets `ovf` (sticky until `reset`);
  - `ovf_cnt` increments and saturates at 255.
- `YM_DBG_CAPTURE_OVF_EN` undefined:
  - the overflow logic is not built;
  - `ovf` and `ovf_cnt` are tied to 0;
  - frames are still dropped identically.

## Structure
- Package `ym_dbg_pkg`:
  - shifter state enum typedef (`IDLE`, `SHIFT`);
  - `ym_dbg_cnt_w(width)` function returning the `bitcnt` width ($clog2(width)).
- Sub-module `ym_dbg_obuf`: single-entry output buffer containing `dout`, `full`, the write/consume/simultaneous logic and the drop strobe.
- The top level holds the FSM, shift register, `bitcnt`, and the overflow flag/counter under the macro.

## Test plan
- **Basic capture.** `FRAME_WIDTH`=8; load, then 8 strobes of `sdata`=1,0,1,0,0,1,0,1 → `dout`=8'hA5, `dout_valid` high one cycle after the 8th strobe, `busy` low.
- **Back-to-back.** `dout_ready` tied 1; frames 8'h3C then 8'hC3 separated by the minimum spacing → both words appear in order, `ovf`=0.
- **Overflow.** `dout_ready`=0; three frames 8'h11, 8'h22, 8'h33 → `dout` stays 8'h11, `ovf`=1, `ovf_cnt`=2. Without the macro, `ovf`=0 and `ovf_cnt`=0.
- **Simultaneous.** Completion of 8'h77 on the same edge as the handshake of 8'h55 → `dout_valid` never drops, `dout`=8'h77 next cycle, `ovf`=0.
- **Abort.** Load, 5 strobes, load again, 8 strobes of 8'h0F → `dout`=8'h0F; the partial frame is never presented.
- **Reset mid-op.** `reset` after 4 strobes with `dout_valid`=1 → all outputs 0 the next cycle; stray `c1` strobes in `IDLE` without `load` produce no word.
